// File: rtl/softmax_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : softmax_stream_if
// Purpose  : Valid/ready input and output streams of the softmax_stream block.
// Revision : 1.0 - initial release
// ============================================================================
interface softmax_stream_if #(
  parameter int WIDTH = 16,
  parameter int OUT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface
`default_nettype wire

// File: rtl/softmax_stream.sv
`default_nettype none
// ============================================================================
// Module   : softmax_stream
// Purpose  : Row-wise streaming softmax: max-subtract, base-2 exponent, divide.
// Revision : 1.0 - initial release
// ============================================================================
module softmax_stream #(
  parameter int N     = 4,
  parameter int WIDTH = 16,
  parameter int FBITS = 8,
  parameter int OUT_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  softmax_stream_if.slave sm,
  output logic            busy,
  output logic            err_len
);

  localparam int c_IW  = (N > 1) ? $clog2(N) : 1;
  localparam int c_SW  = FBITS + 2 + $clog2(N);
  localparam int c_EW  = FBITS + 1;
  localparam int c_DW  = $clog2(OUT_W + 1);
  localparam int c_PW  = WIDTH + FBITS + 4;
  localparam int c_L2W = FBITS + 3;

  localparam logic signed [c_L2W-1:0] c_LOG2E =
    c_L2W'(((64'd14426950 << FBITS) + 64'd5000000) / 64'd10000000);
  localparam logic signed [c_PW-1:0]  c_EMAX  = c_PW'(FBITS + 1);
  localparam logic [c_IW-1:0]         c_LAST  = c_IW'(N - 1);
  localparam logic [c_DW-1:0]         c_DLAST = c_DW'(OUT_W);

  localparam logic [1:0] c_LOAD = 2'd0;
  localparam logic [1:0] c_EXP  = 2'd1;
  localparam logic [1:0] c_DIV  = 2'd2;
  localparam logic [1:0] c_OUT  = 2'd3;

  logic [1:0]              r_state;
  logic [1:0]              w_next;
  logic                    r_started;
  logic [WIDTH-1:0]        r_buf [N];
  logic [c_IW-1:0]         r_cnt;
  logic [c_IW-1:0]         r_idx;
  logic signed [WIDTH-1:0] r_max;
  logic [c_SW-1:0]         r_sum;
  logic [c_DW-1:0]         r_dcnt;
  logic [c_SW-1:0]         r_rem;
  logic [OUT_W-1:0]        r_shl;
  logic [OUT_W-1:0]        r_quo;
  logic [OUT_W-1:0]        r_q;
  logic                    r_qlast;
  logic                    r_err;

  logic                    w_in_ready;
  logic                    w_out_valid;
  logic                    w_busy;
  logic                    w_acc;
  logic signed [WIDTH-1:0] w_newmax;

  logic signed [WIDTH-1:0] w_x;
  logic signed [WIDTH:0]   w_d;
  logic signed [c_PW-1:0]  w_dx;
  logic signed [c_PW-1:0]  w_lx;
  logic signed [c_PW-1:0]  w_prod;
  logic signed [c_PW-1:0]  w_p;
  logic signed [c_PW-1:0]  w_k;
  logic signed [c_PW-1:0]  w_negk;
  logic [c_EW-1:0]         w_mant;
  logic [c_EW-1:0]         w_e;

  logic [c_EW-1:0]         w_ediv;
  logic [c_SW:0]           w_t;
  logic                    w_ge;
  logic [c_SW-1:0]         w_tsub;
  logic [c_SW-1:0]         w_rem_nx;
  logic [OUT_W-1:0]        w_quo_nx;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_LOAD;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_LOAD: if (w_acc && (r_cnt == c_LAST)) w_next = c_EXP;
      c_EXP:  if (r_idx == c_LAST) w_next = c_DIV;
      c_DIV:  if (r_dcnt == c_DLAST) w_next = c_OUT;
      c_OUT:  if (sm.out_ready) w_next = (r_idx == c_LAST) ? c_LOAD : c_DIV;
      default: w_next = c_LOAD;
    endcase
  end

  // in_ready stays low until the first edge after reset release
  always_comb begin
    w_in_ready  = (r_state == c_LOAD) && r_started;
    w_out_valid = (r_state == c_OUT);
    w_busy      = !((r_state == c_LOAD) && (r_cnt == '0));
  end

  assign w_acc    = sm.in_valid && w_in_ready;
  assign w_newmax = ((r_cnt == '0) || ($signed(sm.in_data) > r_max)) ?
                    $signed(sm.in_data) : r_max;

  // ---------------------------------------------------------------- exponent
  // e = 2^(d*log2e) split into integer k (shift) and fraction f (linear mantissa)
  assign w_x    = $signed(r_buf[r_idx]);
  assign w_d    = {w_x[WIDTH-1], w_x} - {r_max[WIDTH-1], r_max};
  assign w_dx   = c_PW'(w_d);
  assign w_lx   = c_PW'(c_LOG2E);
  assign w_prod = w_dx * w_lx;
  assign w_p    = w_prod >>> FBITS;
  assign w_k    = w_p >>> FBITS;
  assign w_negk = -w_k;
  assign w_mant = {1'b1, w_p[FBITS-1:0]};
  assign w_e    = (w_negk > c_EMAX) ? '0 : (w_mant >> w_negk);

  // ---------------------------------------------------------------- divider
  assign w_ediv   = r_buf[r_idx][c_EW-1:0];
  assign w_t      = {r_rem, r_shl[OUT_W-1]};
  assign w_ge     = (w_t >= {1'b0, r_sum});
  assign w_tsub   = w_t[c_SW-1:0] - r_sum;
  assign w_rem_nx = w_ge ? w_tsub : w_t[c_SW-1:0];
  assign w_quo_nx = {r_quo[OUT_W-2:0], w_ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_started <= 1'b0;
      for (int i = 0; i < N; i++) r_buf[i] <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_max   <= '0;
      r_sum   <= '0;
      r_dcnt  <= '0;
      r_rem   <= '0;
      r_shl   <= '0;
      r_quo   <= '0;
      r_q     <= '0;
      r_qlast <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_started <= 1'b1;
      r_err     <= 1'b0;
      case (r_state)
        c_LOAD: begin
          if (w_acc) begin
            if (r_cnt == c_LAST) begin
              r_buf[r_cnt] <= sm.in_data;
              r_max        <= w_newmax;
              r_cnt        <= '0;
              r_idx        <= '0;
              r_err        <= !sm.in_last;
            end else if (sm.in_last) begin
              r_err <= 1'b1;
              r_cnt <= '0;
              r_max <= '0;
            end else begin
              r_buf[r_cnt] <= sm.in_data;
              r_max        <= w_newmax;
              r_cnt        <= r_cnt + c_IW'(1);
            end
          end
        end
        c_EXP: begin
          r_buf[r_idx] <= WIDTH'(w_e);
          r_sum        <= r_sum + c_SW'(w_e);
          r_dcnt       <= '0;
          r_idx        <= (r_idx == c_LAST) ? '0 : r_idx + c_IW'(1);
        end
        c_DIV: begin
          if (r_dcnt == '0) begin
            // dividend e*2^(OUT_W-1): high part e>>1 seeds the remainder
            r_rem  <= c_SW'(w_ediv >> 1);
            r_shl  <= {w_ediv[0], {(OUT_W-1){1'b0}}};
            r_quo  <= '0;
            r_dcnt <= r_dcnt + c_DW'(1);
          end else begin
            r_rem <= w_rem_nx;
            r_shl <= r_shl << 1;
            r_quo <= w_quo_nx;
            if (r_dcnt == c_DLAST) begin
              r_q     <= w_quo_nx;
              r_qlast <= (r_idx == c_LAST);
              r_dcnt  <= '0;
            end else begin
              r_dcnt <= r_dcnt + c_DW'(1);
            end
          end
        end
        c_OUT: begin
          if (sm.out_ready) begin
            r_dcnt <= '0;
            if (r_idx == c_LAST) begin
              for (int i = 0; i < N; i++) r_buf[i] <= '0;
              r_idx <= '0;
              r_cnt <= '0;
              r_max <= '0;
              r_sum <= '0;
            end else begin
              r_idx <= r_idx + c_IW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sm.in_ready  = w_in_ready;
  assign sm.out_valid = w_out_valid;
  assign sm.out_data  = r_q;
  assign sm.out_last  = r_qlast;
  assign busy         = w_busy;
  assign err_len      = r_err;

endmodule
`default_nettype wire
